axi_lite_to_axi_bridge: RTL and testbench
=========================================

// Module: axi_lite_to_axi_bridge
//
// PURPOSE
// AXI-Lite slave port to AXI4 master port bridge. Lets AXI-Lite initiators
// (config masters, lite testbench drivers) reach full-AXI slaves and crossbars.
// Issues every Lite access as a single-beat AXI4 burst with a fixed ID.
// One outstanding write and one outstanding read; the read and write paths run
// independently. All AXI-side requests and Lite-side responses are registered.
//
// PARAMETERS
// AXI_ADDR_WIDTH  32  address width, both ports
// AXI_DATA_WIDTH  32  data width, both ports (no width conversion)
// AXI_ID_WIDTH    8   ID width of the AXI4 master port
// AXI_USER_WIDTH  8   user width of the AXI4 master port; all user fields driven '0
// TXN_ID          '0  ID driven on out.aw_id and out.ar_id
//
// PORTS
// clk_i       in   1     clock; all logic on the rising edge
// rst_ni      in   1     asynchronous reset, active low
// testmode_i  in   1     test mode; no functional effect
// in          AXI_LITE.Slave  AW/DW   Lite request and response port
// out         AXI_BUS.Master  AW/DW/IW/UW  AXI4 master port
//
// BEHAVIOUR
// - Write FSM states: W_IDLE -> W_ISSUE -> W_WAIT_B -> W_SEND_B -> W_IDLE.
//   - W_IDLE: in.aw_ready=1 until AW is captured; in.w_ready=1 until W is
//     captured. Captures are independent, in either order or in the same cycle.
//     Go to W_ISSUE when both are held.
//   - W_ISSUE: out.aw_valid and out.w_valid (w_last=1, w_strb=captured strb)
//     asserted from registers. Each is dropped after its own handshake.
//     Go to W_WAIT_B once both handshakes are done.
//   - W_WAIT_B: out.b_ready=1. On the handshake, store b_resp; go to W_SEND_B.
//   - W_SEND_B: in.b_valid=1 with the stored resp until in.b_ready; then W_IDLE.
// - Read FSM states: R_IDLE -> R_ISSUE -> R_WAIT_R -> R_SEND_R -> R_IDLE.
//   - R_IDLE: in.ar_ready=1; on the handshake, capture the address.
//   - R_ISSUE: out.ar_valid=1 until its handshake.
//   - R_WAIT_R: out.r_ready=1; capture r_data and r_resp.
//     Response forced to SLVERR (2'b10) if r_last=0 or r_id!=TXN_ID.
//   - R_SEND_R: in.r_valid=1 until in.r_ready.
// - AX fields on out: len=0, size=$clog2(DW/8), burst=INCR,
//   lock/cache/prot/qos/region/atop/user all '0.
// - Latency
//   - Lite AW+W complete in cycle N -> out.aw_valid/out.w_valid in cycle N+1.
//   - out B handshake in cycle M -> in.b_valid in cycle M+1.
//   - The read path has the same 1-cycle latency in each direction.
// - Handshake rules
//   - A valid, once asserted, holds with stable payload until its ready.
//   - No output valid depends combinationally on the same-channel ready.
// - Reset values: all out.*_valid=0, in.b_valid=0, in.r_valid=0,
//   out.b_ready=0, out.r_ready=0. in.aw_ready, in.w_ready and in.ar_ready are
//   1 (IDLE). Payload registers are '0.
// - Boundaries
//   - Stray B/R outside the WAIT states is never accepted (ready=0).
//   - A second Lite request stalls (ready=0) until the current one reaches IDLE.
//   - Read and write may complete in the same cycle; no cross-dependency.
//   - Reset asserted mid-transaction: FSMs return to IDLE immediately, all
//     valids drop and the in-flight transaction is discarded.
//
// TESTING
// 1. Lite AW addr=0x1000 and W data=0xDEADBEEF strb=0xF, same cycle, slave
//    B OKAY -> out AW addr=0x1000 len=0 id=TXN_ID, W last=1, Lite B resp=OKAY;
//    one cycle of latency each way.
// 2. Lite W three cycles before AW, and out.aw_ready held 0 for 5 cycles ->
//    out.w handshake completes first; in.b_valid only after both handshakes
//    and B.
// 3. Lite AR addr=0x2004, slave R data=0x12345678 last=1 OKAY
//    -> Lite R data=0x12345678 resp=OKAY.
// 4. Slave R with last=0, and separately r_id!=TXN_ID -> Lite R resp=SLVERR.
// 5. Concurrent write and read with in.b_ready/in.r_ready held 0 for 4 cycles
//    -> valids and payloads stable; both complete; second AR stalled meanwhile.
// 6. rst_ni pulsed low while in W_WAIT_B -> all valids 0 at once; next write
//    completes normally.

Source files
------------

// File: rtl/axi_lite_to_axi_bridge.sv
// AXI-Lite slave to AXI4 master bridge: each Lite access becomes a single-beat
// INCR burst with a fixed ID; one outstanding write and one outstanding read.
module axi_lite_to_axi_bridge #(
    parameter int unsigned AXI_ADDR_WIDTH = 32,
    parameter int unsigned AXI_DATA_WIDTH = 32,
    parameter int unsigned AXI_ID_WIDTH   = 8,
    parameter int unsigned AXI_USER_WIDTH = 8,
    parameter logic [AXI_ID_WIDTH-1:0] TXN_ID = '0
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic                          testmode_i,
    input  logic [AXI_ADDR_WIDTH-1:0]     in_aw_addr,
    input  logic [2:0]                    in_aw_prot,
    input  logic                          in_aw_valid,
    output logic                          in_aw_ready,
    input  logic [AXI_DATA_WIDTH-1:0]     in_w_data,
    input  logic [AXI_DATA_WIDTH/8-1:0]   in_w_strb,
    input  logic                          in_w_valid,
    output logic                          in_w_ready,
    output logic [1:0]                    in_b_resp,
    output logic                          in_b_valid,
    input  logic                          in_b_ready,
    input  logic [AXI_ADDR_WIDTH-1:0]     in_ar_addr,
    input  logic [2:0]                    in_ar_prot,
    input  logic                          in_ar_valid,
    output logic                          in_ar_ready,
    output logic [AXI_DATA_WIDTH-1:0]     in_r_data,
    output logic [1:0]                    in_r_resp,
    output logic                          in_r_valid,
    input  logic                          in_r_ready,
    output logic [AXI_ID_WIDTH-1:0]       out_aw_id,
    output logic [AXI_ADDR_WIDTH-1:0]     out_aw_addr,
    output logic [7:0]                    out_aw_len,
    output logic [2:0]                    out_aw_size,
    output logic [1:0]                    out_aw_burst,
    output logic                          out_aw_lock,
    output logic [3:0]                    out_aw_cache,
    output logic [2:0]                    out_aw_prot,
    output logic [3:0]                    out_aw_qos,
    output logic [3:0]                    out_aw_region,
    output logic [5:0]                    out_aw_atop,
    output logic [AXI_USER_WIDTH-1:0]     out_aw_user,
    output logic                          out_aw_valid,
    input  logic                          out_aw_ready,
    output logic [AXI_DATA_WIDTH-1:0]     out_w_data,
    output logic [AXI_DATA_WIDTH/8-1:0]   out_w_strb,
    output logic                          out_w_last,
    output logic [AXI_USER_WIDTH-1:0]     out_w_user,
    output logic                          out_w_valid,
    input  logic                          out_w_ready,
    input  logic [AXI_ID_WIDTH-1:0]       out_b_id,
    input  logic [1:0]                    out_b_resp,
    input  logic [AXI_USER_WIDTH-1:0]     out_b_user,
    input  logic                          out_b_valid,
    output logic                          out_b_ready,
    output logic [AXI_ID_WIDTH-1:0]       out_ar_id,
    output logic [AXI_ADDR_WIDTH-1:0]     out_ar_addr,
    output logic [7:0]                    out_ar_len,
    output logic [2:0]                    out_ar_size,
    output logic [1:0]                    out_ar_burst,
    output logic                          out_ar_lock,
    output logic [3:0]                    out_ar_cache,
    output logic [2:0]                    out_ar_prot,
    output logic [3:0]                    out_ar_qos,
    output logic [3:0]                    out_ar_region,
    output logic [AXI_USER_WIDTH-1:0]     out_ar_user,
    output logic                          out_ar_valid,
    input  logic                          out_ar_ready,
    input  logic [AXI_ID_WIDTH-1:0]       out_r_id,
    input  logic [AXI_DATA_WIDTH-1:0]     out_r_data,
    input  logic [1:0]                    out_r_resp,
    input  logic                          out_r_last,
    input  logic [AXI_USER_WIDTH-1:0]     out_r_user,
    input  logic                          out_r_valid,
    output logic                          out_r_ready
);

    localparam int unsigned STRB_W = AXI_DATA_WIDTH / 8;
    localparam logic [2:0]  SIZE   = 3'($clog2(STRB_W));

    typedef enum logic [1:0] {W_IDLE, W_ISSUE, W_WAIT_B, W_SEND_B} w_state_t;
    typedef enum logic [1:0] {R_IDLE, R_ISSUE, R_WAIT_R, R_SEND_R} r_state_t;

    w_state_t w_state_q, w_state_d;
    r_state_t r_state_q, r_state_d;
    logic aw_held_q, aw_held_d, w_held_q, w_held_d;
    logic aw_done_q, aw_done_d, w_done_q, w_done_d;
    logic [AXI_ADDR_WIDTH-1:0] aw_addr_q, ar_addr_q;
    logic [AXI_DATA_WIDTH-1:0] w_data_q, r_data_q;
    logic [STRB_W-1:0]         w_strb_q;
    logic [1:0]                b_resp_q, r_resp_q;

    // Lite protection bits and the AXI B/R side-band fields carry no meaning here.
    logic unused;
    assign unused = ^{testmode_i, in_aw_prot, in_ar_prot, out_b_id, out_b_user, out_r_user};

    assign out_aw_id     = TXN_ID;
    assign out_aw_addr   = aw_addr_q;
    assign out_aw_len    = 8'd0;
    assign out_aw_size   = SIZE;
    assign out_aw_burst  = 2'b01;
    assign out_aw_lock   = 1'b0;
    assign out_aw_cache  = 4'd0;
    assign out_aw_prot   = 3'd0;
    assign out_aw_qos    = 4'd0;
    assign out_aw_region = 4'd0;
    assign out_aw_atop   = 6'd0;
    assign out_aw_user   = '0;
    assign out_w_data    = w_data_q;
    assign out_w_strb    = w_strb_q;
    assign out_w_last    = 1'b1;
    assign out_w_user    = '0;
    assign in_b_resp     = b_resp_q;
    assign out_ar_id     = TXN_ID;
    assign out_ar_addr   = ar_addr_q;
    assign out_ar_len    = 8'd0;
    assign out_ar_size   = SIZE;
    assign out_ar_burst  = 2'b01;
    assign out_ar_lock   = 1'b0;
    assign out_ar_cache  = 4'd0;
    assign out_ar_prot   = 3'd0;
    assign out_ar_qos    = 4'd0;
    assign out_ar_region = 4'd0;
    assign out_ar_user   = '0;
    assign in_r_data     = r_data_q;
    assign in_r_resp     = r_resp_q;

    // Held/done flags: once set, the matching ready/valid is already low, so
    // OR-ing in the raw valid/ready is exactly the handshake.
    always_comb begin
        w_state_d    = w_state_q;
        aw_held_d    = aw_held_q;
        w_held_d     = w_held_q;
        aw_done_d    = aw_done_q;
        w_done_d     = w_done_q;
        in_aw_ready  = 1'b0;
        in_w_ready   = 1'b0;
        out_aw_valid = 1'b0;
        out_w_valid  = 1'b0;
        out_b_ready  = 1'b0;
        in_b_valid   = 1'b0;
        unique case (w_state_q)
            W_IDLE: begin
                in_aw_ready = !aw_held_q;
                in_w_ready  = !w_held_q;
                aw_held_d   = aw_held_q | in_aw_valid;
                w_held_d    = w_held_q | in_w_valid;
                if (aw_held_d && w_held_d) begin
                    aw_held_d = 1'b0;
                    w_held_d  = 1'b0;
                    w_state_d = W_ISSUE;
                end
            end
            W_ISSUE: begin
                out_aw_valid = !aw_done_q;
                out_w_valid  = !w_done_q;
                aw_done_d    = aw_done_q | out_aw_ready;
                w_done_d     = w_done_q | out_w_ready;
                if (aw_done_d && w_done_d) begin
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    w_state_d = W_WAIT_B;
                end
            end
            W_WAIT_B: begin
                out_b_ready = 1'b1;
                if (out_b_valid) w_state_d = W_SEND_B;
            end
            W_SEND_B: begin
                in_b_valid = 1'b1;
                if (in_b_ready) w_state_d = W_IDLE;
            end
            default: w_state_d = W_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            w_state_q <= W_IDLE;
            aw_held_q <= 1'b0;
            w_held_q  <= 1'b0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            aw_addr_q <= '0;
            w_data_q  <= '0;
            w_strb_q  <= '0;
            b_resp_q  <= '0;
        end else begin
            w_state_q <= w_state_d;
            aw_held_q <= aw_held_d;
            w_held_q  <= w_held_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
            if (in_aw_valid && in_aw_ready) aw_addr_q <= in_aw_addr;
            if (in_w_valid && in_w_ready) begin
                w_data_q <= in_w_data;
                w_strb_q <= in_w_strb;
            end
            if (out_b_valid && out_b_ready) b_resp_q <= out_b_resp;
        end
    end

    always_comb begin
        r_state_d    = r_state_q;
        in_ar_ready  = 1'b0;
        out_ar_valid = 1'b0;
        out_r_ready  = 1'b0;
        in_r_valid   = 1'b0;
        unique case (r_state_q)
            R_IDLE: begin
                in_ar_ready = 1'b1;
                if (in_ar_valid) r_state_d = R_ISSUE;
            end
            R_ISSUE: begin
                out_ar_valid = 1'b1;
                if (out_ar_ready) r_state_d = R_WAIT_R;
            end
            R_WAIT_R: begin
                out_r_ready = 1'b1;
                if (out_r_valid) r_state_d = R_SEND_R;
            end
            R_SEND_R: begin
                in_r_valid = 1'b1;
                if (in_r_ready) r_state_d = R_IDLE;
            end
            default: r_state_d = R_IDLE;
        endcase
    end

    // A truncated burst or a foreign ID means the beat cannot be trusted.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state_q <= R_IDLE;
            ar_addr_q <= '0;
            r_data_q  <= '0;
            r_resp_q  <= '0;
        end else begin
            r_state_q <= r_state_d;
            if (in_ar_valid && in_ar_ready) ar_addr_q <= in_ar_addr;
            if (out_r_valid && out_r_ready) begin
                r_data_q <= out_r_data;
                r_resp_q <= (out_r_last && (out_r_id == TXN_ID)) ? out_r_resp : 2'b10;
            end
        end
    end

endmodule

// File: tb/tb_axi_lite_to_axi_bridge.sv
// Directed bench for axi_lite_to_axi_bridge: transaction-level model checked on
// every falling edge, plus hand-computed literal expectations per scenario.
module tb_axi_lite_to_axi_bridge;

    localparam logic [7:0] TXN = 8'h00;

    logic        clk_i, rst_ni, testmode_i;
    logic [31:0] in_aw_addr;  logic [2:0] in_aw_prot;  logic in_aw_valid, in_aw_ready;
    logic [31:0] in_w_data;   logic [3:0] in_w_strb;   logic in_w_valid, in_w_ready;
    logic [1:0]  in_b_resp;   logic in_b_valid, in_b_ready;
    logic [31:0] in_ar_addr;  logic [2:0] in_ar_prot;  logic in_ar_valid, in_ar_ready;
    logic [31:0] in_r_data;   logic [1:0] in_r_resp;   logic in_r_valid, in_r_ready;
    logic [7:0]  out_aw_id;   logic [31:0] out_aw_addr; logic [7:0] out_aw_len;
    logic [2:0]  out_aw_size; logic [1:0] out_aw_burst; logic out_aw_lock;
    logic [3:0]  out_aw_cache; logic [2:0] out_aw_prot; logic [3:0] out_aw_qos, out_aw_region;
    logic [5:0]  out_aw_atop; logic [7:0] out_aw_user; logic out_aw_valid, out_aw_ready;
    logic [31:0] out_w_data;  logic [3:0] out_w_strb;  logic out_w_last;
    logic [7:0]  out_w_user;  logic out_w_valid, out_w_ready;
    logic [7:0]  out_b_id;    logic [1:0] out_b_resp;  logic [7:0] out_b_user;
    logic        out_b_valid, out_b_ready;
    logic [7:0]  out_ar_id;   logic [31:0] out_ar_addr; logic [7:0] out_ar_len;
    logic [2:0]  out_ar_size; logic [1:0] out_ar_burst; logic out_ar_lock;
    logic [3:0]  out_ar_cache; logic [2:0] out_ar_prot; logic [3:0] out_ar_qos, out_ar_region;
    logic [7:0]  out_ar_user; logic out_ar_valid, out_ar_ready;
    logic [7:0]  out_r_id;    logic [31:0] out_r_data; logic [1:0] out_r_resp;
    logic        out_r_last;  logic [7:0] out_r_user;  logic out_r_valid, out_r_ready;

    axi_lite_to_axi_bridge dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .testmode_i(testmode_i),
        .in_aw_addr(in_aw_addr), .in_aw_prot(in_aw_prot), .in_aw_valid(in_aw_valid), .in_aw_ready(in_aw_ready),
        .in_w_data(in_w_data), .in_w_strb(in_w_strb), .in_w_valid(in_w_valid), .in_w_ready(in_w_ready),
        .in_b_resp(in_b_resp), .in_b_valid(in_b_valid), .in_b_ready(in_b_ready),
        .in_ar_addr(in_ar_addr), .in_ar_prot(in_ar_prot), .in_ar_valid(in_ar_valid), .in_ar_ready(in_ar_ready),
        .in_r_data(in_r_data), .in_r_resp(in_r_resp), .in_r_valid(in_r_valid), .in_r_ready(in_r_ready),
        .out_aw_id(out_aw_id), .out_aw_addr(out_aw_addr), .out_aw_len(out_aw_len), .out_aw_size(out_aw_size),
        .out_aw_burst(out_aw_burst), .out_aw_lock(out_aw_lock), .out_aw_cache(out_aw_cache),
        .out_aw_prot(out_aw_prot), .out_aw_qos(out_aw_qos), .out_aw_region(out_aw_region),
        .out_aw_atop(out_aw_atop), .out_aw_user(out_aw_user), .out_aw_valid(out_aw_valid),
        .out_aw_ready(out_aw_ready),
        .out_w_data(out_w_data), .out_w_strb(out_w_strb), .out_w_last(out_w_last), .out_w_user(out_w_user),
        .out_w_valid(out_w_valid), .out_w_ready(out_w_ready),
        .out_b_id(out_b_id), .out_b_resp(out_b_resp), .out_b_user(out_b_user),
        .out_b_valid(out_b_valid), .out_b_ready(out_b_ready),
        .out_ar_id(out_ar_id), .out_ar_addr(out_ar_addr), .out_ar_len(out_ar_len), .out_ar_size(out_ar_size),
        .out_ar_burst(out_ar_burst), .out_ar_lock(out_ar_lock), .out_ar_cache(out_ar_cache),
        .out_ar_prot(out_ar_prot), .out_ar_qos(out_ar_qos), .out_ar_region(out_ar_region),
        .out_ar_user(out_ar_user), .out_ar_valid(out_ar_valid), .out_ar_ready(out_ar_ready),
        .out_r_id(out_r_id), .out_r_data(out_r_data), .out_r_resp(out_r_resp), .out_r_last(out_r_last),
        .out_r_user(out_r_user), .out_r_valid(out_r_valid), .out_r_ready(out_r_ready)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    int vectors = 0;
    int miscompares = 0;

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    // Transaction-level model: where each of the one write and one read stands.
    bit          m_aw_got, m_w_got, m_winf, m_aw_sent, m_w_sent, m_b_got;
    bit          m_rinf, m_ar_sent, m_r_got;
    logic [31:0] m_aw_addr, m_w_data, m_ar_addr, m_r_data;
    logic [3:0]  m_w_strb;
    logic [1:0]  m_b_resp, m_r_resp;

    always @(negedge clk_i) begin
        bit e_awr, e_wr, e_awv, e_wv, e_br, e_bv, e_arr, e_arv, e_rr, e_rv;
        if (!rst_ni) begin
            {m_aw_got, m_w_got, m_winf, m_aw_sent, m_w_sent, m_b_got} = '0;
            {m_rinf, m_ar_sent, m_r_got} = '0;
        end
        e_awr = !m_winf && !m_aw_got;
        e_wr  = !m_winf && !m_w_got;
        e_awv = m_winf && !m_aw_sent;
        e_wv  = m_winf && !m_w_sent;
        e_br  = m_winf && m_aw_sent && m_w_sent && !m_b_got;
        e_bv  = m_winf && m_b_got;
        e_arr = !m_rinf;
        e_arv = m_rinf && !m_ar_sent;
        e_rr  = m_rinf && m_ar_sent && !m_r_got;
        e_rv  = m_rinf && m_r_got;
        chk("in_aw_ready", in_aw_ready, e_awr);
        chk("in_w_ready", in_w_ready, e_wr);
        chk("out_aw_valid", out_aw_valid, e_awv);
        chk("out_w_valid", out_w_valid, e_wv);
        chk("out_b_ready", out_b_ready, e_br);
        chk("in_b_valid", in_b_valid, e_bv);
        chk("in_ar_ready", in_ar_ready, e_arr);
        chk("out_ar_valid", out_ar_valid, e_arv);
        chk("out_r_ready", out_r_ready, e_rr);
        chk("in_r_valid", in_r_valid, e_rv);
        if (e_awv) begin
            chk("out_aw_addr", out_aw_addr, m_aw_addr);
            chk("out_aw_fields", {out_aw_id, out_aw_len, out_aw_size, out_aw_burst}, {TXN, 8'd0, 3'd2, 2'b01});
            chk("out_aw_zero", {out_aw_lock, out_aw_cache, out_aw_prot, out_aw_qos, out_aw_region,
                                out_aw_atop, out_aw_user}, '0);
        end
        if (e_wv) begin
            chk("out_w_data", out_w_data, m_w_data);
            chk("out_w_strb_last_user", {out_w_strb, out_w_last, out_w_user}, {m_w_strb, 1'b1, 8'd0});
        end
        if (e_bv) chk("in_b_resp", in_b_resp, m_b_resp);
        if (e_arv) begin
            chk("out_ar_addr", out_ar_addr, m_ar_addr);
            chk("out_ar_fields", {out_ar_id, out_ar_len, out_ar_size, out_ar_burst}, {TXN, 8'd0, 3'd2, 2'b01});
            chk("out_ar_zero", {out_ar_lock, out_ar_cache, out_ar_prot, out_ar_qos, out_ar_region,
                                out_ar_user}, '0);
        end
        if (e_rv) begin
            chk("in_r_data", in_r_data, m_r_data);
            chk("in_r_resp", in_r_resp, m_r_resp);
        end
        if (rst_ni) begin
            if (in_aw_valid && e_awr) begin m_aw_got = 1; m_aw_addr = in_aw_addr; end
            if (in_w_valid && e_wr) begin m_w_got = 1; m_w_data = in_w_data; m_w_strb = in_w_strb; end
            if (m_aw_got && m_w_got) begin m_winf = 1; m_aw_got = 0; m_w_got = 0; end
            if (e_awv && out_aw_ready) m_aw_sent = 1;
            if (e_wv && out_w_ready) m_w_sent = 1;
            if (e_br && out_b_valid) begin m_b_got = 1; m_b_resp = out_b_resp; end
            if (e_bv && in_b_ready) {m_winf, m_aw_sent, m_w_sent, m_b_got} = '0;
            if (in_ar_valid && e_arr) begin m_rinf = 1; m_ar_addr = in_ar_addr; end
            if (e_arv && out_ar_ready) m_ar_sent = 1;
            if (e_rr && out_r_valid) begin
                m_r_got  = 1;
                m_r_data = out_r_data;
                m_r_resp = (out_r_last && out_r_id == TXN) ? out_r_resp : 2'b10;
            end
            if (e_rv && in_r_ready) {m_rinf, m_ar_sent, m_r_got} = '0;
        end
    end

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                            input logic [1:0] bresp);
        bit a, w;
        int k;
        in_aw_addr = addr; in_w_data = data; in_w_strb = strb;
        in_aw_valid = 1; in_w_valid = 1;
        for (k = 0; k < 20 && (in_aw_valid || in_w_valid); k++) begin
            a = in_aw_ready; w = in_w_ready;
            step();
            if (a) in_aw_valid = 0;
            if (w) in_w_valid = 0;
        end
        k = 0;
        while (!out_b_ready && k < 20) begin step(); k++; end
        chk("wr_b_ready_reached", out_b_ready, 1);
        out_b_valid = 1; out_b_resp = bresp;
        step();
        out_b_valid = 0;
        chk("wr_lite_b_valid", in_b_valid, 1);
        chk("wr_lite_b_resp", in_b_resp, bresp);
        in_b_ready = 1;
        step();
        chk("wr_lite_b_done", in_b_valid, 0);
    endtask

    task automatic do_read(input logic [31:0] addr, input logic [31:0] rdata, input logic rlast,
                           input logic [7:0] rid, input logic [1:0] rresp, input logic [1:0] exp_resp);
        int k;
        in_ar_addr = addr; in_ar_valid = 1;
        k = 0;
        while (!in_ar_ready && k < 20) begin step(); k++; end
        step();
        in_ar_valid = 0;
        chk("rd_ar_latency", out_ar_valid, 1);
        chk("rd_ar_addr", out_ar_addr, addr);
        k = 0;
        while (!out_r_ready && k < 20) begin step(); k++; end
        chk("rd_r_ready_reached", out_r_ready, 1);
        out_r_valid = 1; out_r_data = rdata; out_r_last = rlast; out_r_id = rid; out_r_resp = rresp;
        step();
        out_r_valid = 0;
        chk("rd_lite_r_valid", in_r_valid, 1);
        chk("rd_lite_r_data", in_r_data, rdata);
        chk("rd_lite_r_resp", in_r_resp, exp_resp);
        in_r_ready = 1;
        step();
        chk("rd_lite_r_done", in_r_valid, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout, want $finish");
        $fatal(1);
    end

    initial begin
        rst_ni = 0; testmode_i = 0;
        in_aw_addr = '0; in_aw_prot = '0; in_aw_valid = 0;
        in_w_data = '0; in_w_strb = '0; in_w_valid = 0; in_b_ready = 0;
        in_ar_addr = '0; in_ar_prot = '0; in_ar_valid = 0; in_r_ready = 0;
        out_aw_ready = 0; out_w_ready = 0; out_ar_ready = 0;
        out_b_id = '0; out_b_resp = '0; out_b_user = '0; out_b_valid = 0;
        out_r_id = '0; out_r_data = '0; out_r_resp = '0; out_r_last = 0; out_r_user = '0; out_r_valid = 0;
        step(); step();
        chk("rst_valids", {out_aw_valid, out_w_valid, out_ar_valid, in_b_valid, in_r_valid}, 5'b0);
        chk("rst_readies", {out_b_ready, out_r_ready, in_aw_ready, in_w_ready, in_ar_ready}, 5'b00111);
        chk("rst_payload", {out_aw_addr, out_w_data}, 64'h0);
        rst_ni = 1;
        step();

        // 1: AW and W in the same cycle, one cycle each way.
        out_aw_ready = 1; out_w_ready = 1; out_ar_ready = 1; in_b_ready = 1;
        in_aw_addr = 32'h1000; in_w_data = 32'hDEADBEEF; in_w_strb = 4'hF;
        in_aw_valid = 1; in_w_valid = 1;
        step();
        in_aw_valid = 0; in_w_valid = 0;
        chk("t1_aw_valid_n1", out_aw_valid, 1);
        chk("t1_aw_addr", out_aw_addr, 32'h1000);
        chk("t1_aw_len_id", {out_aw_len, out_aw_id}, {8'd0, TXN});
        chk("t1_w_valid_n1", out_w_valid, 1);
        chk("t1_w_data", out_w_data, 32'hDEADBEEF);
        chk("t1_w_last_strb", {out_w_last, out_w_strb}, 5'h1F);
        step();
        chk("t1_aw_dropped", out_aw_valid, 0);
        chk("t1_b_ready", out_b_ready, 1);
        out_b_valid = 1; out_b_resp = 2'b00;
        step();
        out_b_valid = 0;
        chk("t1_lite_b_valid_m1", in_b_valid, 1);
        chk("t1_lite_b_resp", in_b_resp, 2'b00);
        step();
        chk("t1_idle_again", {in_b_valid, in_aw_ready, in_w_ready}, 3'b011);

        // 2: W three cycles before AW, AW side stalled by the slave.
        out_aw_ready = 0;
        in_w_data = 32'hCAFEF00D; in_w_strb = 4'h3; in_w_valid = 1;
        step();
        in_w_valid = 0;
        chk("t2_w_held", {in_w_ready, in_aw_ready}, 2'b01);
        step(); step();
        in_aw_addr = 32'h1010; in_aw_valid = 1;
        step();
        in_aw_valid = 0;
        chk("t2_issue", {out_aw_valid, out_w_valid}, 2'b11);
        chk("t2_w_payload", {out_w_data, out_w_strb}, {32'hCAFEF00D, 4'h3});
        step();
        chk("t2_w_first", {out_w_valid, out_aw_valid}, 2'b01);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("t2_no_b_yet", {out_b_ready, in_b_valid, out_aw_valid}, 3'b001);
            chk("t2_aw_addr_stable", out_aw_addr, 32'h1010);
        end
        out_aw_ready = 1;
        step();
        chk("t2_b_ready_after_both", {out_aw_valid, out_b_ready}, 2'b01);
        out_b_valid = 1; out_b_resp = 2'b11;
        step();
        out_b_valid = 0;
        chk("t2_lite_b", {in_b_valid, in_b_resp}, 3'b111);
        step();

        // 3 and 4: plain read, then responses that must turn into SLVERR.
        do_read(32'h2004, 32'h12345678, 1'b1, TXN, 2'b00, 2'b00);
        do_read(32'h2008, 32'h0000BEEF, 1'b0, TXN, 2'b00, 2'b10);
        do_read(32'h200C, 32'h55AA55AA, 1'b1, 8'h05, 2'b00, 2'b10);
        do_read(32'h2010, 32'h0F0F0F0F, 1'b1, TXN, 2'b01, 2'b01);

        // 5: concurrent write and read, Lite side back-pressured for 4 cycles.
        in_b_ready = 0; in_r_ready = 0;
        in_aw_addr = 32'h3000; in_w_data = 32'h0BADF00D; in_w_strb = 4'hC;
        in_ar_addr = 32'h3008;
        in_aw_valid = 1; in_w_valid = 1; in_ar_valid = 1;
        step();
        in_aw_valid = 0; in_w_valid = 0; in_ar_valid = 0;
        chk("t5_both_issue", {out_aw_valid, out_w_valid, out_ar_valid}, 3'b111);
        step();
        chk("t5_both_wait", {out_b_ready, out_r_ready}, 2'b11);
        out_b_valid = 1; out_b_resp = 2'b01;
        out_r_valid = 1; out_r_data = 32'hA5A5A5A5; out_r_last = 1; out_r_id = TXN; out_r_resp = 2'b00;
        step();
        out_b_valid = 0; out_r_valid = 0;
        in_ar_addr = 32'h4000; in_ar_valid = 1;
        for (int i = 0; i < 4; i++) begin
            chk("t5_hold_valids", {in_b_valid, in_r_valid, in_ar_ready}, 3'b110);
            chk("t5_hold_payload", {in_b_resp, in_r_data, in_r_resp}, {2'b01, 32'hA5A5A5A5, 2'b00});
            step();
        end
        in_b_ready = 1; in_r_ready = 1;
        step();
        chk("t5_both_done", {in_b_valid, in_r_valid, in_ar_ready}, 3'b001);
        step();
        in_ar_valid = 0;
        chk("t5_second_ar", {out_ar_valid, out_ar_addr}, {1'b1, 32'h4000});
        step();
        out_r_valid = 1; out_r_data = 32'h44440000;
        step();
        out_r_valid = 0;
        chk("t5_second_r", {in_r_valid, in_r_data}, {1'b1, 32'h44440000});
        step();

        // 6: reset pulse while waiting for B, stray responses, then a clean write.
        in_aw_addr = 32'h5000; in_w_data = 32'h11112222; in_w_strb = 4'hF;
        in_aw_valid = 1; in_w_valid = 1;
        step();
        in_aw_valid = 0; in_w_valid = 0;
        step();
        chk("t6_in_wait_b", out_b_ready, 1);
        rst_ni = 0;
        #1;
        chk("t6_rst_valids", {out_aw_valid, out_w_valid, out_ar_valid, in_b_valid, in_r_valid}, 5'b0);
        chk("t6_rst_readies", {out_b_ready, out_r_ready, in_aw_ready, in_w_ready, in_ar_ready}, 5'b00111);
        step();
        rst_ni = 1;
        out_b_valid = 1; out_b_resp = 2'b10; out_r_valid = 1;
        step(); step();
        chk("t6_stray_ignored", {out_b_ready, out_r_ready, in_b_valid, in_r_valid}, 4'b0);
        out_b_valid = 0; out_r_valid = 0;
        step();
        do_write(32'h5004, 32'h600DF00D, 4'hF, 2'b00);

        @(negedge clk_i);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
